min_search_ctrl: RTL

- Sequencer for the two-minimum search pipeline (MIN1→MIN2→MIN3 stages).
- Accepts a start command with a candidate count. Clears the pipeline's minimum trackers, then issues candidate indices one per cycle. Flags the last candidate so it propagates as TriggerBoss.
- Waits for TriggerBoss to emerge from the final stage, then captures the two minima and holds them until acknowledged.

---
 rtl/min_search_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/min_search_ctrl.sv
// rtl/min_search_ctrl.sv - sequencer for the two-minimum search pipeline
// Optional EARLY_EXIT_EN: cut the issue phase short once min1_value reaches zero.
module min_search_ctrl #(
    parameter int PIPE_DEPTH  = 4,
    parameter int DRAIN_SLACK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_candidates,
    input  logic        stall,
    output logic        clear,
    output logic        issue_valid,
    output logic [15:0] issue_index,
    output logic        issue_last,
    input  logic        min_trigger,
    input  logic [15:0] min1_index,
    input  logic [13:0] min1_value,
    input  logic [15:0] min2_index,
    input  logic [13:0] min2_value,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [15:0] res_min1_index,
    output logic [13:0] res_min1_value,
    output logic [15:0] res_min2_index,
    output logic [13:0] res_min2_value,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [15:0] DRAIN_LIMIT = 16'(PIPE_DEPTH + DRAIN_SLACK - 1);
    localparam logic [15:0] IDX_RESET   = 16'hFFFF;
    localparam logic [13:0] VAL_RESET   = 14'h3FFF;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] n_reg;
    logic [15:0] cnt;
    logic [15:0] drain_cnt;
    logic        is_last;
    logic        drain_expired;

`ifdef EARLY_EXIT_EN
    localparam logic [15:0] EARLY_MIN = 16'(PIPE_DEPTH + 1);
    logic early_now;
    logic early_hit;

    // A perfect match seen during a stall is remembered until the next real issue.
    assign early_now = (state == S_ISSUE) && (cnt >= EARLY_MIN) && (min1_value == 14'd0);
    assign is_last   = (cnt == n_reg - 16'd1) || early_now || early_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_hit <= 1'b0;
        end else if (state == S_CLEAR) begin
            early_hit <= 1'b0;
        end else if (early_now && stall) begin
            early_hit <= 1'b1;
        end
    end
`else
    assign is_last = (cnt == n_reg - 16'd1);
`endif

    assign drain_expired = (drain_cnt == DRAIN_LIMIT);
    assign issue_index   = cnt;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clear       = 1'b0;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear     = 1'b1;
                state_nxt = (n_reg != 16'd0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    issue_valid = 1'b1;
                    issue_last  = is_last;
                    if (is_last) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (min_trigger || drain_expired) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg          <= 16'd0;
            cnt            <= 16'd0;
            drain_cnt      <= 16'd0;
            result_valid   <= 1'b0;
            timeout        <= 1'b0;
            res_min1_index <= IDX_RESET;
            res_min1_value <= VAL_RESET;
            res_min2_index <= IDX_RESET;
            res_min2_value <= VAL_RESET;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_reg          <= num_candidates;
                        cnt            <= 16'd0;
                        timeout        <= 1'b0;
                        res_min1_index <= IDX_RESET;
                        res_min1_value <= VAL_RESET;
                        res_min2_index <= IDX_RESET;
                        res_min2_value <= VAL_RESET;
                    end
                end
                S_CLEAR: begin
                    cnt       <= 16'd0;
                    drain_cnt <= 16'd0;
                    if (n_reg == 16'd0) begin
                        result_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    drain_cnt <= 16'd0;
                    // The counter parks on the last index so N=16'hFFFF never wraps.
                    if (!stall && !is_last) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 16'd1;
                    if (min_trigger) begin
                        res_min1_index <= min1_index;
                        res_min1_value <= min1_value;
                        res_min2_index <= min2_index;
                        res_min2_value <= min2_value;
                        result_valid   <= 1'b1;
                    end else if (drain_expired) begin
                        timeout      <= 1'b1;
                        result_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
